decode_stage_ctrl: RTL and testbench

//  Decode-stage front end: accepts fetched {pc, ir} over valid/ready, classifies
//  the opcode into instr_type and drives the imm_gen_32 instance with it.

---
 rtl/decode_stage_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_decode_stage_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_ctrl.sv
// Decode-stage front end: classifies fetched instructions, registers the
// decoded bundle toward execute through a 2-entry skid buffer, and counts
// illegal instructions consumed by execute.
//
// Handshake rules for both ports:
// - A transfer happens on a rising clock edge where valid and ready are both 1.
// - A producer holding valid=1 keeps its payload stable until the transfer.
// - in_ready and out_valid are register outputs. They never depend
//   combinationally on in_valid or out_ready.

// Immediate generator: builds the sign-extended 32-bit immediate selected by
// the instruction format. The R format has no immediate and yields zero.
module imm_gen_32 (
  input  logic [31:0] ir_i,
  input  logic [2:0]  instr_type_i,
  output logic [31:0] imm_o
);
  localparam logic [2:0] INSTR_R = 3'd0;
  localparam logic [2:0] INSTR_I = 3'd1;
  localparam logic [2:0] INSTR_S = 3'd2;
  localparam logic [2:0] INSTR_B = 3'd3;
  localparam logic [2:0] INSTR_U = 3'd4;
  localparam logic [2:0] INSTR_J = 3'd5;

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^ir_i[6:0];

  // Select the immediate layout for the given format.
  always_comb begin
    imm_o = 32'd0;
    case (instr_type_i)
      INSTR_I: imm_o = {{20{ir_i[31]}}, ir_i[31:20]};
      INSTR_S: imm_o = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
      INSTR_B: imm_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25],
                        ir_i[11:8], 1'b0};
      INSTR_U: imm_o = {ir_i[31:12], 12'd0};
      INSTR_J: imm_o = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20],
                        ir_i[30:21], 1'b0};
      INSTR_R: imm_o = 32'd0;
      default: imm_o = 32'd0;
    endcase
  end
endmodule

module decode_stage_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ir,
  output logic [XLEN-1:0]  out_pc,
  output logic [2:0]       out_instr_type,
  output logic [31:0]      out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [1:0]       dbg_state
);
  localparam logic [2:0] INSTR_R = 3'd0;
  localparam logic [2:0] INSTR_I = 3'd1;
  localparam logic [2:0] INSTR_S = 3'd2;
  localparam logic [2:0] INSTR_B = 3'd3;
  localparam logic [2:0] INSTR_U = 3'd4;
  localparam logic [2:0] INSTR_J = 3'd5;

  // EMPTY: nothing held. ONE: main slot holds the output bundle.
  // FULL: main slot and skid slot are both occupied.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       main_ir_q, main_ir_d, skid_ir_q, skid_ir_d;
  logic [XLEN-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [2:0]        main_type_q, main_type_d, skid_type_q, skid_type_d;
  logic              main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]        in_type;
  logic              in_illegal;
  logic              accept;
  logic              pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  // Classify the incoming opcode. Unknown opcodes are flagged illegal and use R format.
  always_comb begin
    in_type    = INSTR_R;
    in_illegal = 1'b0;
    case (in_ir[6:0])
      7'b0110111, 7'b0010111: in_type = INSTR_U;
      7'b1101111:             in_type = INSTR_J;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b0001111, 7'b1110011: in_type = INSTR_I;
      7'b1100011:             in_type = INSTR_B;
      7'b0100011:             in_type = INSTR_S;
      7'b0110011:             in_type = INSTR_R;
      default: begin
        in_type    = INSTR_R;
        in_illegal = 1'b1;
      end
    endcase
  end

  // Skid buffer next state and slot updates. Flush overrides everything.
  always_comb begin
    state_d     = state_q;
    main_ir_d   = main_ir_q;
    main_pc_d   = main_pc_q;
    main_type_d = main_type_q;
    main_ill_d  = main_ill_q;
    skid_ir_d   = skid_ir_q;
    skid_pc_d   = skid_pc_q;
    skid_type_d = skid_type_q;
    skid_ill_d  = skid_ill_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_ir_d   = in_ir;
            main_pc_d   = in_pc;
            main_type_d = in_type;
            main_ill_d  = in_illegal;
            state_d     = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            main_ir_d   = in_ir;
            main_pc_d   = in_pc;
            main_type_d = in_type;
            main_ill_d  = in_illegal;
          end else if (accept) begin
            skid_ir_d   = in_ir;
            skid_pc_d   = in_pc;
            skid_type_d = in_type;
            skid_ill_d  = in_illegal;
            state_d     = S_FULL;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            main_ir_d   = skid_ir_q;
            main_pc_d   = skid_pc_q;
            main_type_d = skid_type_q;
            main_ill_d  = skid_ill_q;
            state_d     = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != S_FULL);
    out_valid_d = (state_d != S_EMPTY);
  end

  // Count illegal bundles taken by execute. The count saturates and ignores flush.
  always_comb begin
    cnt_d = cnt_q;
    if (pop && main_ill_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, slot and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ir_q   <= 32'd0;
      main_pc_q   <= '0;
      main_type_q <= INSTR_R;
      main_ill_q  <= 1'b0;
      skid_ir_q   <= 32'd0;
      skid_pc_q   <= '0;
      skid_type_q <= INSTR_R;
      skid_ill_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_ir_q   <= main_ir_d;
      main_pc_q   <= main_pc_d;
      main_type_q <= main_type_d;
      main_ill_q  <= main_ill_d;
      skid_ir_q   <= skid_ir_d;
      skid_pc_q   <= skid_pc_d;
      skid_type_q <= skid_type_d;
      skid_ill_q  <= skid_ill_d;
      cnt_q       <= cnt_d;
    end
  end

  imm_gen_32 u_imm_gen (
    .ir_i         (main_ir_q),
    .instr_type_i (main_type_q),
    .imm_o        (out_imm)
  );

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_ir         = main_ir_q;
  assign out_pc         = main_pc_q;
  assign out_instr_type = main_type_q;
  assign out_illegal    = main_ill_q;
  assign out_rs1        = main_ir_q[19:15];
  assign out_rs2        = main_ir_q[24:20];
  assign out_rd         = main_ir_q[11:7];
  assign illegal_cnt    = cnt_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Testbench for decode_stage_ctrl: directed scenarios plus randomized traffic,
// checked against a queue-occupancy reference model.
module tb_decode_stage_ctrl;
  localparam int CW = 4;
  localparam int W  = 115;
  localparam logic [2:0] T_R = 3'd0;
  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4;
  localparam logic [2:0] T_J = 3'd5;

  logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_ir, in_pc, out_ir, out_pc, out_imm;
  logic [2:0]    out_instr_type;
  logic [4:0]    out_rs1, out_rs2, out_rd;
  logic          out_illegal;
  logic [CW-1:0] illegal_cnt;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] cnt_m;

  decode_stage_ctrl #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir),
    .out_pc(out_pc), .out_instr_type(out_instr_type), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: expected bundle {ir, pc, type, imm, illegal, rs1, rs2, rd}.
  function automatic logic [W-1:0] ref_bundle(input logic [31:0] ir, input logic [31:0] pc);
    logic [2:0]  t;
    logic        ill;
    logic [31:0] imm;
    ill = 1'b0;
    t   = T_R;
    case (ir[6:0])
      7'h37, 7'h17:                   t = T_U;
      7'h6F:                          t = T_J;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: t = T_I;
      7'h63:                          t = T_B;
      7'h23:                          t = T_S;
      7'h33:                          t = T_R;
      default: begin t = T_R; ill = 1'b1; end
    endcase
    imm = 32'd0;
    if (t == T_I) imm = 32'($signed(ir[31:20]));
    if (t == T_S) imm = 32'($signed({ir[31:25], ir[11:7]}));
    if (t == T_B) imm = 32'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    if (t == T_U) imm = ir & 32'hFFFF_F000;
    if (t == T_J) imm = 32'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
    return {ir, pc, t, imm, ill, ir[19:15], ir[24:20], ir[11:7]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard / monitor: compare outputs with the model, then advance the
  // model across the coming rising edge (pop, then flush or accept).
  always @(negedge clk) begin
    logic do_pop, do_acc;
    if (rst) begin
      exp_q.delete();
      cnt_m = '0;
    end else begin
      chk("out_valid", out_valid, exp_q.size() > 0);
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("illegal_cnt", illegal_cnt, cnt_m);
      if (exp_q.size() > 0)
        chk("bundle", {out_ir, out_pc, out_instr_type, out_imm, out_illegal,
                       out_rs1, out_rs2, out_rd}, exp_q[0]);
      do_pop = (exp_q.size() > 0) && out_ready;
      do_acc = in_valid && (exp_q.size() < 2);
      if (do_pop) begin
        if (exp_q[0][15] && cnt_m != {CW{1'b1}}) cnt_m = cnt_m + 1'b1;
        void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (do_acc) exp_q.push_back(ref_bundle(in_ir, in_pc));
    end
  end

  // Driver: offer one word and hold it until it is accepted (bounded).
  task automatic send(input logic [31:0] ir, input logic [31:0] pc);
    logic acc;
    in_valid = 1'b1;
    in_ir    = ir;
    in_pc    = pc;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout: got no accept expected accept for ir %h", ir);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                           7'h0F, 7'h73, 7'h63, 7'h23};

  initial begin
    logic [31:0] r;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ir = '0; in_pc = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_cnt", illegal_cnt, '0);
    chk("rst_bundle", {out_ir, out_pc, out_instr_type, out_imm, out_illegal,
                       out_rs1, out_rs2, out_rd}, '0);
    @(posedge clk); #3 rst = 1'b0;
    idle(1);

    // Test 1: addi x1,x0,5 visible the cycle after acceptance
    out_ready = 1'b1;
    send(32'h0050_0093, 32'h100);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_type", out_instr_type, T_I);
    chk("t1_imm", out_imm, 32'h5);
    chk("t1_rd", out_rd, 5'd1);
    chk("t1_illegal", out_illegal, 1'b0);

    // Test 2: lui and beq immediates
    send(32'h1234_5137, 32'h104);
    chk("t2_lui_type", out_instr_type, T_U);
    chk("t2_lui_imm", out_imm, 32'h1234_5000);
    send(32'hFE00_0EE3, 32'h108);
    chk("t2_beq_type", out_instr_type, T_B);
    chk("t2_beq_imm", out_imm, 32'hFFFF_FFFC);
    idle(3);

    // Test 3: back-pressure fills both slots, then drains in order
    out_ready = 1'b0;
    send(32'h0050_0093, 32'h200);
    send(32'h00A0_0113, 32'h204);
    chk("t3_full_in_ready", in_ready, 1'b0);
    fork
      send(32'h00F0_0193, 32'h208);
      begin idle(3); out_ready = 1'b1; end
    join
    idle(4);

    // Test 4: flush while FULL with a word offered in the same cycle
    out_ready = 1'b0;
    send(32'h0010_0093, 32'h300);
    send(32'h0020_0093, 32'h304);
    flush = 1'b1; in_valid = 1'b1; in_ir = 32'h0030_0093; in_pc = 32'h308;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_out_valid", out_valid, 1'b0);
    chk("t4_in_ready", in_ready, 1'b1);
    idle(3);
    out_ready = 1'b1;
    idle(2);

    // Test 5: illegal words, count and saturation
    send(32'h0000_0000, 32'h400);
    send(32'hFFFF_FFFF, 32'h404);
    idle(3);
    chk("t5_cnt2", illegal_cnt, 4'd2);
    for (int i = 0; i < 14; i++) send(32'hFFFF_FFFF, 32'h500 + 4 * i);
    idle(3);
    chk("t5_cnt_sat", illegal_cnt, {CW{1'b1}});

    // Test 6: asynchronous reset while FULL
    out_ready = 1'b0;
    send(32'h0050_0093, 32'h600);
    send(32'h00A0_0113, 32'h604);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_cnt", illegal_cnt, '0);
    chk("t6_bundle", {out_ir, out_pc, out_instr_type, out_imm, out_illegal,
                      out_rs1, out_rs2, out_rd}, '0);
    idle(2);
    @(posedge clk); #3 rst = 1'b0;
    idle(1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_pc     = $urandom();
      if ($urandom_range(0, 7) == 0) in_ir = r;
      else in_ir = {r[31:7], ops[$urandom_range(0, 9)]};
      if ($urandom_range(0, 9) == 0) in_ir = {r[31:7], 7'h33};
      idle(1);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
